uart_top: RTL and testbench
===========================

// Module: uart_top
// PURPOSE
//   Self-contained 8N1 UART transmitter plus receiver sharing one clock.
//   TX serialises Tx_Data onto Pin. RX deserialises Pin, which is internally looped back.
//   Top-level block for UART link bring-up and loopback verification.
//   RX reports each frame as a valid byte, a break, or a silently dropped framing error.
// PARAMETERS
//   CLK_HZ        50_000_000  system clock frequency (Hz)
//   BIT_RATE      9600        line baud rate
//   PAYLOAD_BITS  8           data bits per frame
//   CLKS_PER_BIT  CLK_HZ/BIT_RATE (=5208, localparam; integer division, truncated)
// PORTS
//   clk           in   1  single system clock, rising edge; clocks TX and RX
//   rst           in   1  reset, synchronous, active-high
//   Enable_Tx     in   1  level; while high and TX idle, start a frame
//   Enable_Rx     in   1  level; while high, RX may detect start bits
//   Tx_Data       in   8  byte to send; sampled on frame acceptance only
//   Rx_Data       out  8  last correctly received byte (registered)
//   Pin           out  1  serial line (TX output, also RX input internally); idle high
//   Tx_Line_busy  out  1  high from cycle after acceptance until end of stop bit
//   Break         out  1  1-cycle pulse: break frame detected
//   Valid_Data    out  1  1-cycle pulse: Rx_Data updated with a new byte
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): Pin=1, Tx_Line_busy=0, Rx_Data=0, Valid_Data=0,
//     Break=0; both FSMs go to IDLE; counters clear. Reset mid-frame aborts it at once.
//   TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//     IDLE: Pin=1. If Enable_Tx=1, latch Tx_Data into the shift register, go START,
//       and set busy=1 on the next edge.
//     START: Pin=0 for CLKS_PER_BIT cycles.
//     DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
//     STOP: Pin=1 for CLKS_PER_BIT cycles. Then IDLE and busy=0.
//     Enable_Tx held high: the next frame is accepted on the first IDLE cycle.
//       This gives exactly one idle cycle between frames.
//     Tx_Data changes mid-frame have no effect on the frame in flight.
//     Deasserting Enable_Tx mid-frame does not abort the frame.
//   RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//     Pin passes through a 2-FF synchroniser before use.
//     IDLE: synchronised falling edge (1->0) with Enable_Rx=1 -> START.
//     START: wait CLKS_PER_BIT/2. If the line is still 0, go DATA; else false start -> IDLE.
//     DATA: sample every CLKS_PER_BIT at mid-bit; shift LSB first; 8 samples.
//     STOP: sample at mid stop bit, then go IDLE.
//       stop=1 -> Rx_Data<=shift register; Valid_Data=1 for one cycle.
//       stop=0 and data==0 -> Break=1 for one cycle; Rx_Data unchanged.
//         RX then waits for the line to return high before re-arming.
//       stop=0 and data!=0 -> framing error; frame dropped, no pulse.
//     Enable_Rx low in IDLE ignores the line. Dropping it mid-frame does not abort.
//     Valid_Data and Break are mutually exclusive; both are 0 in every other cycle.
//   Loopback latency: start-bit edge to Valid_Data = 9.5 bit times + 2-3 cycles.
//     Valid_Data is high while Tx_Line_busy is still high (during the stop bit).
//   Counters: bit-period counter ceil(log2(CLKS_PER_BIT)) bits; bit index 3 bits.
//     Counters wrap to 0 at each bit boundary.
// TESTING
//   rst=1 for 3 cycles -> Pin=1, busy=0, Rx_Data=0x00, Valid_Data=0, Break=0.
//   Enable_Tx=Enable_Rx=1, Tx_Data=0xA5 -> Pin frame 0,1,0,1,0,0,1,0,1,1 at 5208 clk/bit;
//     Valid_Data pulse with Rx_Data=0xA5; busy=1 for 52080 cycles.
//   Back-to-back 0x00, 0xFF, 0x3C with Enable_Tx held -> three Valid_Data pulses,
//     Rx_Data 0x00, 0xFF, 0x3C in order; 1 idle cycle between frames.
//   Line held low for 12 bit times (internal loopback forced) -> one Break pulse,
//     no Valid_Data, Rx_Data unchanged; RX re-arms after the line returns high.
//   Enable_Rx=0 while 0x5A is sent -> no Valid_Data, Rx_Data unchanged.
//   rst pulsed mid-DATA of frame 0x81 -> Pin=1 and busy=0 after that edge;
//     no Valid_Data for the aborted frame; next 0x42 is received correctly.

Source files
------------

// File: rtl/uart_top.sv
// 8N1 UART transmitter and receiver on one clock, with the serial line looped
// back internally from the TX output to the RX input.
module uart_top #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Enable_Tx,
    input  logic                    Enable_Rx,
    input  logic [PAYLOAD_BITS-1:0] Tx_Data,
    output logic [PAYLOAD_BITS-1:0] Rx_Data,
    output logic                    Pin,
    output logic                    Tx_Line_busy,
    output logic                    Break,
    output logic                    Valid_Data
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W        = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    tx_state_t                tx_state;
    logic [CNT_W-1:0]         tx_cnt;
    logic [IDX_W-1:0]         tx_idx;
    logic [PAYLOAD_BITS-1:0]  tx_shift;

    rx_state_t                rx_state;
    logic [CNT_W-1:0]         rx_cnt;
    logic [IDX_W-1:0]         rx_idx;
    logic [PAYLOAD_BITS-1:0]  rx_shift;

    logic                     rx_line;
    logic                     sync_1;
    logic                     sync_2;
    logic                     sync_prev;

    // Internal loopback: the receiver listens to the transmitter's line
    assign rx_line = Pin;

    // TX FSM: start bit, LSB-first payload, stop bit; busy spans the whole frame
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state     <= TX_IDLE;
            tx_cnt       <= '0;
            tx_idx       <= '0;
            tx_shift     <= '0;
            Pin          <= 1'b1;
            Tx_Line_busy <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    Pin          <= 1'b1;
                    Tx_Line_busy <= 1'b0;
                    tx_cnt       <= '0;
                    tx_idx       <= '0;
                    if (Enable_Tx) begin
                        tx_shift     <= Tx_Data;
                        Pin          <= 1'b0;
                        Tx_Line_busy <= 1'b1;
                        tx_state     <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        Pin      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[PAYLOAD_BITS-1:1]};
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
                            Pin      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            Pin      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[PAYLOAD_BITS-1:1]};
                            tx_idx   <= tx_idx + IDX_W'(1);
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt       <= '0;
                        Tx_Line_busy <= 1'b0;
                        tx_state     <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_1    <= rx_line;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    // RX FSM: mid-bit sampling; classifies each frame as byte, break or dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            Rx_Data    <= '0;
            Valid_Data <= 1'b0;
            Break      <= 1'b0;
        end else begin
            Valid_Data <= 1'b0;
            Break      <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                    if (Enable_Rx && sync_prev && !sync_2) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= sync_2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {sync_2, rx_shift[PAYLOAD_BITS-1:1]};
                        if (rx_idx == IDX_LAST) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + IDX_W'(1);
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (sync_2) begin
                            Rx_Data    <= rx_shift;
                            Valid_Data <= 1'b1;
                            rx_state   <= RX_IDLE;
                        end else if (rx_shift == '0) begin
                            Break    <= 1'b1;
                            rx_state <= RX_WAIT_HIGH;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (sync_2) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_top.sv
// Loopback bench for uart_top: directed frames, scoreboard of expected RX events.
module tb_uart_top;

    localparam int unsigned CLK_HZ   = 160;
    localparam int unsigned BIT_RATE = 10;
    localparam int unsigned CPB      = 16;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       en_tx   = 1'b0;
    logic       en_rx   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       pin;
    logic       busy;
    logic       brk;
    logic       valid;

    typedef struct packed {
        logic       is_break;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    uart_top #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Enable_Tx   (en_tx),
        .Enable_Rx   (en_rx),
        .Tx_Data     (tx_data),
        .Rx_Data     (rx_data),
        .Pin         (pin),
        .Tx_Line_busy(busy),
        .Break       (brk),
        .Valid_Data  (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Queue one frame: Tx_Data and Enable_Tx set, accepted at the next edge, then released
    task automatic start_frame(input logic [7:0] d);
        @(posedge clk);
        #1 tx_data = d;
        en_tx = 1'b1;
        @(posedge clk);
        #1 en_tx = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic measure_gap(input string name);
        int gap;
        gap = 0;
        while (busy === 1'b0 && gap < 5) begin
            gap++;
            @(negedge clk);
        end
        check({name, "_idle_gap"}, 32'(gap), 32'd1);
    endtask

    // Monitor: every Valid_Data/Break pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && (valid || brk)) begin
            checks++;
            if (valid && brk) begin
                errors++;
                $display("FAIL rx_event: got valid=1 break=1, expected exclusive pulses");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got valid=%0b break=%0b data=0x%0h, expected no event",
                         valid, brk, rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (valid && (mon_e.is_break || rx_data !== mon_e.data)) begin
                    errors++;
                    $display("FAIL rx_byte: got valid data=0x%0h, expected break=%0b data=0x%0h",
                             rx_data, mon_e.is_break, mon_e.data);
                end else if (brk && !mon_e.is_break) begin
                    errors++;
                    $display("FAIL rx_break: got break, expected byte 0x%0h", mon_e.data);
                end
            end
            if (valid) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_in_stop: got busy=%0b, expected 1", busy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] frame;
        int         busy_cnt;

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pin", 32'(pin), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_break", 32'(brk), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        en_rx = 1'b1;

        // 0xA5: line shape, busy length, loopback byte
        frame = 10'b1101001010;
        exp_q.push_back('{is_break: 1'b0, data: 8'hA5});
        start_frame(8'hA5);
        busy_cnt = 0;
        for (int m = 0; m < int'(10 * CPB); m++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (m % CPB == CPB / 2)
                check($sformatf("a5_bit%0d", m / CPB), 32'(pin), 32'(frame[m / CPB]));
        end
        @(negedge clk);
        check("a5_busy_end", 32'(busy), 32'd0);
        check("a5_busy_cycles", 32'(busy_cnt), 32'(10 * CPB));
        repeat (2 * CPB) @(negedge clk);
        check("a5_rx_data", 32'(rx_data), 32'hA5);

        // Back-to-back 0x00, 0xFF, 0x3C with Enable_Tx held
        exp_q.push_back('{is_break: 1'b0, data: 8'h00});
        exp_q.push_back('{is_break: 1'b0, data: 8'hFF});
        exp_q.push_back('{is_break: 1'b0, data: 8'h3C});
        @(posedge clk);
        #1 tx_data = 8'h00;
        en_tx = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'hFF;
        wait_idle(12 * CPB, "b2b_0");
        measure_gap("b2b_0");
        tx_data = 8'h3C;
        wait_idle(12 * CPB, "b2b_1");
        measure_gap("b2b_1");
        en_tx = 1'b0;
        wait_idle(12 * CPB, "b2b_2");
        repeat (2 * CPB) @(negedge clk);
        check("b2b_rx_data", 32'(rx_data), 32'h3C);

        // Line forced low for 12 bit times -> single break
        repeat (CPB) @(negedge clk);
        exp_q.push_back('{is_break: 1'b1, data: 8'h00});
        force dut.rx_line = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        release dut.rx_line;
        repeat (2 * CPB) @(negedge clk);
        check("break_rx_data", 32'(rx_data), 32'h3C);

        // Enable_Rx low: 0x5A ignored
        en_rx = 1'b0;
        start_frame(8'h5A);
        wait_idle(12 * CPB, "rx_off");
        repeat (2 * CPB) @(negedge clk);
        check("rx_off_rx_data", 32'(rx_data), 32'h3C);
        en_rx = 1'b1;

        // Reset in the middle of 0x81
        start_frame(8'h81);
        repeat (3 * CPB) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_pin", 32'(pin), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rx_data", 32'(rx_data), 32'h00);
        repeat (12 * CPB) @(negedge clk);

        // Recovery frame 0x42
        exp_q.push_back('{is_break: 1'b0, data: 8'h42});
        start_frame(8'h42);
        wait_idle(12 * CPB, "recover");
        repeat (2 * CPB) @(negedge clk);
        check("recover_rx_data", 32'(rx_data), 32'h42);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
